// File: rtl/cs_pkg.sv
// cs_pkg: shared definitions for the CS transmit-side feeder.
//   CS_DATA_W      - sample width seen by CS.X
//   CS_WIN         - CS averaging window length
//   feeder_state_t - feeder control states (IDLE / STREAM)
package cs_pkg;

    localparam int CS_DATA_W = 8;
    localparam int CS_WIN    = 9;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// cs_sync_fifo: single-clock FIFO with registered occupancy.
//   clk, reset     - clock, asynchronous active-high reset
//   clear          - synchronous discard of all contents
//   push, din      - write request and data (ignored when full or clearing)
//   pop            - read request (ignored when empty or clearing)
//   dout           - current head entry
//   full, empty    - occupancy flags
//   count          - number of stored entries
module cs_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

endmodule

// File: rtl/cs_sample_feeder.sv
// cs_sample_feeder: buffers samples from a valid/ready producer and drives
// CS.X at one sample per clock, tracking how many consecutive fresh samples
// CS has captured.
//   clk, reset         - clock shared with CS, asynchronous active-high reset
//   in_data, in_valid  - upstream sample and its valid
//   in_ready           - FIFO can accept (not full and not flushing)
//   flush              - synchronous discard of buffered samples, back to IDLE
//   X                  - registered sample driven to CS.X
//   x_fresh            - X holds a newly popped sample this cycle
//   y_valid            - CS.Y is built from WIN consecutive fresh samples
//   fill_cnt           - FIFO occupancy
//   underrun_cnt       - saturating count of underrun exits from STREAM
//                        (present only when CS_UNDERRUN_CNT_EN is defined)
module cs_sample_feeder
    import cs_pkg::*;
#(
    parameter int DATA_W      = CS_DATA_W,
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 4,
    parameter int WIN         = CS_WIN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [DATA_W-1:0]          X,
    output logic                       x_fresh,
    output logic                       y_valid,
    output logic [$clog2(DEPTH+1)-1:0] fill_cnt
`ifdef CS_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                 underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WIN_W = $clog2(WIN + 1);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(WIN);

    feeder_state_t     state;
    feeder_state_t     state_next;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_next;

    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;

    cs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (fill_cnt >= CNT_W'(START_LEVEL)) state_next = STREAM;
                STREAM:  if (fifo_empty) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        pop = 1'b0;
        if (!flush && state == STREAM) begin
            pop = !fifo_empty;
        end
    end

    // CS captures X on every edge; a stale capture restarts the run.
    always_comb begin
        win_next = '0;
        if (x_fresh) begin
            win_next = (win_cnt == WIN_MAX) ? WIN_MAX : win_cnt + WIN_W'(1);
        end
    end

    // y_valid is registered from the same next value as win_cnt, so it
    // always equals (win_cnt == WIN) without a combinational compare.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            X       <= '0;
            x_fresh <= 1'b0;
            win_cnt <= '0;
            y_valid <= 1'b0;
        end else if (flush) begin
            X       <= '0;
            x_fresh <= 1'b0;
            win_cnt <= '0;
            y_valid <= 1'b0;
        end else begin
            if (pop) begin
                X <= fifo_head;
            end
            x_fresh <= pop;
            win_cnt <= win_next;
            y_valid <= (win_next == WIN_MAX);
        end
    end

`ifdef CS_UNDERRUN_CNT_EN
    logic underrun;

    assign underrun = !flush && (state == STREAM) && fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (underrun && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cs_sample_feeder.sv
// tb_cs_sample_feeder: two feeders (START_LEVEL 4 and 16) share one stimulus
// stream; a queue-based model of each is checked every cycle, with a few
// hand-computed expectations pinning the model.
module tb_cs_sample_feeder;
    import cs_pkg::*;

    localparam int DEPTH = 16;
    localparam int WIN   = CS_WIN;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          flush;
    logic [7:0]    in_data;
    logic          in_ready [2];
    logic [7:0]    X        [2];
    logic          x_fresh  [2];
    logic          y_valid  [2];
    logic [CW-1:0] fill_cnt [2];
`ifdef CS_UNDERRUN_CNT_EN
    logic [7:0]    underrun_cnt [2];
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state, one set per DUT
    logic [7:0] mq     [2][$];
    bit         m_hist [2][$];
    bit         m_stream [2];
    logic [7:0] m_x      [2];
    bit         m_fresh  [2];
    int         m_under  [2];
    int         start_lvl [2] = '{4, 16};
    bit         acc_last  [2];

    int seen [$];

    always #5 clk = ~clk;

    cs_sample_feeder #(.DATA_W(8), .DEPTH(DEPTH), .START_LEVEL(4), .WIN(WIN)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[0]), .flush(flush), .X(X[0]), .x_fresh(x_fresh[0]),
        .y_valid(y_valid[0]), .fill_cnt(fill_cnt[0])
`ifdef CS_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt[0])
`endif
    );

    cs_sample_feeder #(.DATA_W(8), .DEPTH(DEPTH), .START_LEVEL(16), .WIN(WIN)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready[1]), .flush(flush), .X(X[1]), .x_fresh(x_fresh[1]),
        .y_valid(y_valid[1]), .fill_cnt(fill_cnt[1])
`ifdef CS_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt[1])
`endif
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_hist[i].delete();
            m_stream[i] = 0;
            m_x[i]      = '0;
            m_fresh[i]  = 0;
            m_under[i]  = 0;
        end
    endtask

    // y_valid must be high exactly when the last WIN captures were all fresh
    function automatic bit exp_yv(input int i);
        int n = m_hist[i].size();
        if (n < WIN) return 0;
        for (int k = n - WIN; k < n; k++) begin
            if (!m_hist[i][k]) return 0;
        end
        return 1;
    endfunction

    task automatic model_edge(input int i);
        bit acc;
        acc = in_valid && !flush && (mq[i].size() < DEPTH);
        if (flush) begin
            mq[i].delete();
            m_hist[i].delete();
            m_x[i]      = '0;
            m_fresh[i]  = 0;
            m_stream[i] = 0;
        end else begin
            m_hist[i].push_back(m_fresh[i]);
            if (m_hist[i].size() > WIN) void'(m_hist[i].pop_front());
            if (m_stream[i]) begin
                if (mq[i].size() > 0) begin
                    m_x[i]     = mq[i].pop_front();
                    m_fresh[i] = 1;
                end else begin
                    m_fresh[i]  = 0;
                    m_stream[i] = 0;
                    m_under[i]++;
                end
            end else begin
                m_fresh[i] = 0;
                if (mq[i].size() >= start_lvl[i]) m_stream[i] = 1;
            end
            if (acc) mq[i].push_back(in_data);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_X"}, i, X[i], m_x[i]);
            chk({tag, "_fresh"}, i, x_fresh[i], m_fresh[i]);
            chk({tag, "_yvalid"}, i, y_valid[i], exp_yv(i));
            chk({tag, "_fill"}, i, fill_cnt[i], mq[i].size());
`ifdef CS_UNDERRUN_CNT_EN
            chk({tag, "_under"}, i, underrun_cnt[i], (m_under[i] > 255) ? 255 : m_under[i]);
`endif
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, in_ready[i], (mq[i].size() < DEPTH) && !f);
            acc_last[i] = v && in_ready[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_edge(i);
        check_all("cyc");
    endtask

    task automatic do_reset();
        in_valid = 0;
        flush    = 0;
        reset    = 1;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #2 reset = 0;
        #1;
    endtask

    initial begin
        int d;
        bit got;
        int yv_cnt;
        int t1_exp [4] = '{10, 20, 30, 40};

        reset = 1; in_valid = 0; flush = 0; in_data = '0;
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_X", i, X[i], 0);
            chk("rst_fresh", i, x_fresh[i], 0);
            chk("rst_yvalid", i, y_valid[i], 0);
            chk("rst_fill", i, fill_cnt[i], 0);
        end
        @(posedge clk);
        #2 reset = 0;
        #1;
        for (int i = 0; i < 2; i++) chk("rst_in_ready", i, in_ready[i], 1);

        // four samples, then stream them out in order
        seen.delete();
        for (int k = 0; k < 4; k++) cycle(1, 8'(t1_exp[k]), 0);
        chk("t1_fill4", 0, fill_cnt[0], 4);
        for (int k = 0; k < 8; k++) begin
            cycle(0, '0, 0);
            if (x_fresh[0]) seen.push_back(int'(X[0]));
        end
        chk("t1_nfresh", 0, seen.size(), 4);
        for (int k = 0; k < seen.size() && k < 4; k++) chk("t1_order", 0, seen[k], t1_exp[k]);
        cycle(0, '0, 1);

        // 20 back-to-back samples; first y_valid arrives with sample 10 on X
        got = 0;
        for (int s = 1; s <= 35; s++) begin
            cycle(s <= 20, 8'(s), 0);
            if (y_valid[0] && !got) begin
                got = 1;
                chk("t2_x_at_yv", 0, X[0], 10);
            end
        end
        chk("t2_yv_seen", 0, got, 1);

        // nine samples, one underrun, then resume
        do_reset();
        yv_cnt = 0;
        for (int s = 1; s <= 17; s++) begin
            cycle(s <= 9, 8'(s + 100), 0);
            if (y_valid[0]) yv_cnt++;
        end
        chk("t3_yv_cycles", 0, yv_cnt, 1);
`ifdef CS_UNDERRUN_CNT_EN
        chk("t3_under1", 0, underrun_cnt[0], 1);
`endif
        for (int s = 1; s <= 30; s++) cycle(s <= 12, 8'(s + 150), 0);
        cycle(0, '0, 1);

        // fill dut1 to full with in_valid held, then check ordering
        seen.delete();
        d = 1;
        for (int k = 0; k < 16; k++) begin
            cycle(1, 8'(d), 0);
            if (acc_last[1]) d++;
        end
        chk("t4_full_fill", 1, fill_cnt[1], 16);
        chk("t4_full_ready", 1, in_ready[1], 0);
        for (int k = 0; k < 40; k++) begin
            cycle(k < 10, 8'(d), 0);
            if (acc_last[1]) d++;
            if (x_fresh[1]) seen.push_back(int'(X[1]));
        end
        chk("t4_n_out", 1, (seen.size() >= 17), 1);
        for (int k = 0; k < seen.size() && k < 17; k++) chk("t4_order", 1, seen[k], k + 1);
        cycle(0, '0, 1);

        // flush with 7 buffered in dut1 and a coincident push
        for (int k = 0; k < 7; k++) cycle(1, 8'(k + 60), 0);
        chk("t5_fill7", 1, fill_cnt[1], 7);
        cycle(1, 8'd99, 1);
        chk("t5_fill0", 1, fill_cnt[1], 0);
        chk("t5_X0", 1, X[1], 0);
        chk("t5_yv0", 1, y_valid[1], 0);
        cycle(0, '0, 0);
        chk("t5_dropped", 1, fill_cnt[1], 0);

        // asynchronous reset in the middle of streaming
        for (int k = 0; k < 10; k++) cycle(1, 8'(k + 200), 0);
        chk("t6_fill5", 0, fill_cnt[0], 5);
        in_valid = 0;
        #2 reset = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_X", i, X[i], 0);
            chk("t6_fresh", i, x_fresh[i], 0);
            chk("t6_yvalid", i, y_valid[i], 0);
            chk("t6_fill", i, fill_cnt[i], 0);
`ifdef CS_UNDERRUN_CNT_EN
            chk("t6_under", i, underrun_cnt[i], 0);
`endif
        end
        model_reset();
        @(posedge clk);
        #2 reset = 0;
        #1;

        // randomized traffic with varying density and occasional flushes
        for (int ph = 0; ph < 20; ph++) begin
            int p;
            p = int'($urandom_range(1, 4));
            for (int k = 0; k < 80; k++) begin
                cycle(int'($urandom_range(0, 3)) < p, 8'($urandom), $urandom_range(0, 59) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
